bxn_sync_ctrl: RTL

Bunch-crossing counter and BX0 synchronisation controller for the OptoHybrid control path. It counts 0..BXN_MAX locally and aligns to TTC resync/BX0. It checks every later BX0 against the local count and raises a registered trigger-stop request until the link is locked. It also stops triggers on an alignment error. It sits beside the FMM logic and feeds the trigger sequencer and the DAQ header, which uses the L1A-latched BXN.

---
 rtl/bxn_sync_ctrl_if.sv | 33 +++
 rtl/bxn_sync_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/bxn_sync_ctrl_if.sv
// TTC inputs, configuration and status bundle of the BXN / BX0 synchronisation controller.
interface bxn_sync_ctrl_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  localparam int unsigned BXN_W = 12;

  logic                 ttc_bx0;
  logic                 ttc_resync;
  logic                 ttc_l1a;
  logic                 cnt_reset;
  logic [BXN_W-1:0]     bxn_preset;
  logic                 stop_on_err;

  logic [BXN_W-1:0]     bxn_counter;
  logic [BXN_W-1:0]     bxn_l1a;
  logic                 locked;
  logic                 sync_err;
  logic [ERR_CNT_W-1:0] sync_err_cnt;
  logic                 trig_stop;
  logic [1:0]           sm_state;

  // Driver side: TTC decoder and slow-control configuration
  modport master (
    output ttc_bx0, ttc_resync, ttc_l1a, cnt_reset, bxn_preset, stop_on_err,
    input  bxn_counter, bxn_l1a, locked, sync_err, sync_err_cnt, trig_stop, sm_state
  );

  // Controller side
  modport slave (
    input  ttc_bx0, ttc_resync, ttc_l1a, cnt_reset, bxn_preset, stop_on_err,
    output bxn_counter, bxn_l1a, locked, sync_err, sync_err_cnt, trig_stop, sm_state
  );
endinterface

// File: rtl/bxn_sync_ctrl.sv
// Bunch-crossing counter with BX0 alignment, lock supervision and trigger-stop request.
module bxn_sync_ctrl #(
  parameter int unsigned BXN_MAX   = 3563,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  bxn_sync_ctrl_if.slave bus
);

  localparam int unsigned BXN_W = 12;
  localparam logic [BXN_W-1:0]     BXN_LAST = BXN_W'(BXN_MAX);
  localparam logic [ERR_CNT_W-1:0] ERR_SAT  = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BX0 = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  state_t               state_q, state_nxt;
  logic [BXN_W-1:0]     cnt_q, cnt_nxt;
  logic [BXN_W-1:0]     l1a_q;
  logic                 locked_q;
  logic                 sync_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_nxt;
  logic                 trig_stop_q;

  logic [BXN_W-1:0]     preset_eff;
  logic [BXN_W-1:0]     preset_inc;
  logic [BXN_W-1:0]     cnt_inc;
  logic                 at_preset;
  logic                 err_hit;

  // Out-of-range presets map to 0; wrap helpers for the free-running count
  always_comb begin
    preset_eff = (bus.bxn_preset > BXN_LAST) ? '0 : bus.bxn_preset;
    preset_inc = (preset_eff >= BXN_LAST) ? '0 : preset_eff + BXN_W'(1);
    cnt_inc    = (cnt_q >= BXN_LAST) ? '0 : cnt_q + BXN_W'(1);
    at_preset  = (cnt_q == preset_eff);
  end

  // Alignment check while locked: BX0 must coincide exactly with the preset count
  always_comb begin
    err_hit = 1'b0;
    if (state_q == ST_LOCKED && !bus.ttc_resync)
      err_hit = (bus.ttc_bx0 != at_preset);
  end

  // Next state and next count; resync overrides everything below reset
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_inc;
    if (bus.ttc_resync) begin
      state_nxt = ST_WAIT_BX0;
      cnt_nxt   = preset_eff;
    end else begin
      case (state_q)
        ST_IDLE: state_nxt = ST_WAIT_BX0;
        ST_WAIT_BX0: begin
          if (bus.ttc_bx0) begin
            state_nxt = ST_LOCKED;
            cnt_nxt   = preset_inc;
          end
        end
        ST_LOCKED: begin
          if (err_hit && bus.stop_on_err)
            state_nxt = ST_ERROR;
        end
        ST_ERROR: state_nxt = ST_ERROR;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Saturating error counter; a clear wins over a coincident increment
  always_comb begin
    err_cnt_nxt = err_cnt_q;
    if (bus.cnt_reset)
      err_cnt_nxt = '0;
    else if (err_hit && err_cnt_q != ERR_SAT)
      err_cnt_nxt = err_cnt_q + ERR_CNT_W'(1);
  end

  // State, counter and all status outputs registered together
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      l1a_q       <= '0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      trig_stop_q <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      err_cnt_q   <= err_cnt_nxt;
      locked_q    <= (state_nxt == ST_LOCKED);
      trig_stop_q <= (state_nxt != ST_LOCKED);
      if (bus.ttc_l1a)
        l1a_q <= cnt_q;
      if (bus.ttc_resync)
        sync_err_q <= 1'b0;
      else if (err_hit)
        sync_err_q <= 1'b1;
    end
  end

  // Drive the status bundle straight from the registers
  assign bus.bxn_counter  = cnt_q;
  assign bus.bxn_l1a      = l1a_q;
  assign bus.locked       = locked_q;
  assign bus.sync_err     = sync_err_q;
  assign bus.sync_err_cnt = err_cnt_q;
  assign bus.trig_stop    = trig_stop_q;
  assign bus.sm_state     = state_q;

endmodule
